// File: rtl/regfile_mp_pkg.sv
// Shared constants, width helpers and default-width typedefs for the multi-port register file.
//   aw_f(nregs) : register address width
//   cw_f(nregs) : width of a counter that can hold 0..nregs
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;

    function automatic int unsigned aw_f(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    function automatic int unsigned cw_f(input int unsigned nregs);
        return $clog2(nregs + 1);
    endfunction

    localparam int unsigned AW_DEF = aw_f(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   addr_t;
    typedef logic [XLEN_DEF-1:0] data_t;

    localparam data_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Issue/writeback bus of the register file.
//   master : drives write ports, read addresses and claims; sees read data, busy flags, pending count
//   slave  : the register file side
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
);
    localparam int unsigned AW = aw_f(NREGS);
    localparam int unsigned CW = cw_f(NREGS);

    logic [NWR-1:0]           RegWrite;
    logic [NWR-1:0][AW-1:0]   wa;
    logic [NWR-1:0][XLEN-1:0] wd;
    logic [NRD-1:0][AW-1:0]   ra;
    logic [NRD-1:0][XLEN-1:0] rd;
    logic [NRD-1:0]           rbusy;
    logic                     claim_en;
    logic [AW-1:0]            claim_addr;
    logic [CW-1:0]            pending_cnt;

    modport master (
        output RegWrite, wa, wd, ra, claim_en, claim_addr,
        input  rd, rbusy, pending_cnt
    );

    modport slave (
        input  RegWrite, wa, wd, ra, claim_en, claim_addr,
        output rd, rbusy, pending_cnt
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count of busy registers.
//   clk, reset      : clock, synchronous active-high reset
//   we_i, wa_i      : write ports (a write to a register clears its busy bit)
//   claim_en_i/addr : issue-time claim (sets busy; wins over a same-cycle clear)
//   ra_i, fwd_i     : read addresses and "operand forwarded this cycle" flags
//   rbusy_c_o       : combinational busy lookup per read port
//   pending_cnt_o   : registered number of busy registers
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS = 32,
    parameter  int unsigned NRD   = 2,
    parameter  int unsigned NWR   = 1,
    localparam int unsigned AW    = aw_f(NREGS),
    localparam int unsigned CW    = cw_f(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NWR-1:0]         we_i,
    input  logic [NWR-1:0][AW-1:0] wa_i,
    input  logic                   claim_en_i,
    input  logic [AW-1:0]          claim_addr_i,
    input  logic [NRD-1:0][AW-1:0] ra_i,
    input  logic [NRD-1:0]         fwd_i,
    output logic [NRD-1:0]         rbusy_c_o,
    output logic [CW-1:0]          pending_cnt_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] clr_c, set_c;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    n_up_c, n_dn_c;

    // Next busy vector; x0 never participates. The count moves only by bits that actually flip,
    // so re-claiming a busy register or writing a non-busy one leaves it unchanged.
    always_comb begin
        clr_c  = '0;
        set_c  = '0;
        n_up_c = '0;
        n_dn_c = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (we_i[j]) clr_c[wa_i[j]] = 1'b1;
        end
        if (claim_en_i) set_c[claim_addr_i] = 1'b1;
        clr_c[0] = 1'b0;
        set_c[0] = 1'b0;
        busy_d   = (busy_q & ~clr_c) | set_c;
        for (int unsigned k = 0; k < NREGS; k++) begin
            n_up_c = n_up_c + CW'(busy_d[k] & ~busy_q[k]);
            n_dn_c = n_dn_c + CW'(busy_q[k] & ~busy_d[k]);
        end
        cnt_d = cnt_q + n_up_c - n_dn_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // A forwarded operand is ready this cycle even if its register is still marked busy.
    always_comb begin
        rbusy_c_o = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rbusy_c_o[i] = !reset && !fwd_i[i] && busy_q[ra_i[i]];
        end
    end

    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, optional write-to-read bypass
// and a per-register pending scoreboard.
//   clk, reset : clock, synchronous active-high reset
//   bus        : regfile_mp_if.slave -- write ports (RegWrite/wa/wd), read ports (ra -> rd, rbusy,
//                combinational), claim port (claim_en/claim_addr), registered pending_cnt
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);

    localparam int unsigned AW = aw_f(NREGS);
    localparam int unsigned CW = cw_f(NREGS);

    typedef logic [XLEN-1:0] word_t;

    word_t                    regs_q [NREGS];
    word_t                    regs_d [NREGS];
    logic [NRD-1:0][XLEN-1:0] rd_c;
    logic [NRD-1:0]           fwd_c;
    logic [NRD-1:0]           rbusy_c;
    logic [CW-1:0]            pending_cnt;

    // Write decode: ports scanned in ascending order so the highest index wins a collision.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (bus.RegWrite[j] && (bus.wa[j] != '0)) regs_d[bus.wa[j]] = bus.wd[j];
        end
        regs_d[0] = XLEN'(REG_ZERO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NREGS; k++) regs_q[k] <= XLEN'(REG_ZERO);
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes with optional forwarding from the highest-index hitting write port.
    always_comb begin
        rd_c  = '0;
        fwd_c = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_c[i] = regs_q[bus.ra[i]];
            if (BYPASS != 0) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (bus.RegWrite[j] && (bus.wa[j] == bus.ra[i])) begin
                        rd_c[i]  = bus.wd[j];
                        fwd_c[i] = 1'b1;
                    end
                end
            end
            if (reset || (bus.ra[i] == '0)) rd_c[i] = '0;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_sb (
        .clk           (clk),
        .reset         (reset),
        .we_i          (bus.RegWrite),
        .wa_i          (bus.wa),
        .claim_en_i    (bus.claim_en),
        .claim_addr_i  (bus.claim_addr),
        .ra_i          (bus.ra),
        .fwd_i         (fwd_c),
        .rbusy_c_o     (rbusy_c),
        .pending_cnt_o (pending_cnt)
    );

    assign bus.rd          = rd_c;
    assign bus.rbusy       = rbusy_c;
    assign bus.pending_cnt = pending_cnt;

endmodule
